// File: rtl/cam_sccb_config.sv
// OV7670 register loader: walks a fixed {sub-address, data} table and emits one SCCB 3-phase write per entry.
// Define CAM_SCCB_TEST_PATTERN_EN to append the colour-bar test-pattern entries to the table.
module cam_sccb_config #(
    parameter int         CLK_FREQ    = 25_000_000,
    parameter int         SCCB_FREQ   = 100_000,
    parameter logic [7:0] CAM_ID      = 8'h42,
    parameter int         RST_WAIT_MS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [4:0] reg_idx
);

    localparam int Q       = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int RST_CYC = (RST_WAIT_MS * CLK_FREQ) / 1000;
`ifdef CAM_SCCB_TEST_PATTERN_EN
    localparam int N_REGS  = 11;
`else
    localparam int N_REGS  = 9;
`endif

    typedef enum logic [2:0] {
        IDLE, LOAD, START, BYTE, STOP, GAP, RST_WAIT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tickCnt_q, tickCnt_d;
    logic [2:0]  qtr_q, qtr_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [31:0] waitCnt_q, waitCnt_d;
    logic [4:0]  regIdx_q, regIdx_d;
    logic [7:0]  subAddr_q, subAddr_d;
    logic [7:0]  data_q, data_d;
    logic        doneFlag_q, doneFlag_d;

    logic [7:0]  romSub, romData;
    logic [7:0]  curByte;
    logic        active, tick;

    always_comb begin
        {romSub, romData} = 16'h0000;
        case (regIdx_q)
            5'd0:    {romSub, romData} = 16'h1280;
            5'd1:    {romSub, romData} = 16'h1204;
            5'd2:    {romSub, romData} = 16'h8C02;
            5'd3:    {romSub, romData} = 16'h40D0;
            5'd4:    {romSub, romData} = 16'h1101;
            5'd5:    {romSub, romData} = 16'h0C04;
            5'd6:    {romSub, romData} = 16'h3E1A;
            5'd7:    {romSub, romData} = 16'h7222;
            5'd8:    {romSub, romData} = 16'h73F2;
`ifdef CAM_SCCB_TEST_PATTERN_EN
            5'd9:    {romSub, romData} = 16'h70BA;
            5'd10:   {romSub, romData} = 16'h71B5;
`endif
            default: {romSub, romData} = 16'h0000;
        endcase
    end

    // The quarter-bit divider only runs while the bus is being driven, so every phase starts on a fresh count.
    assign active = (state_q == START) || (state_q == BYTE) || (state_q == STOP) || (state_q == GAP);
    assign tick   = active && (tickCnt_q == 16'(Q - 1));

    always_comb begin
        case (byteCnt_q)
            2'd0:    curByte = CAM_ID;
            2'd1:    curByte = subAddr_q;
            default: curByte = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            qtr_q      <= '0;
            bitCnt_q   <= '0;
            byteCnt_q  <= '0;
            waitCnt_q  <= '0;
            regIdx_q   <= '0;
            subAddr_q  <= '0;
            data_q     <= '0;
            doneFlag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            qtr_q      <= qtr_d;
            bitCnt_q   <= bitCnt_d;
            byteCnt_q  <= byteCnt_d;
            waitCnt_q  <= waitCnt_d;
            regIdx_q   <= regIdx_d;
            subAddr_q  <= subAddr_d;
            data_q     <= data_d;
            doneFlag_q <= doneFlag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tickCnt_d  = (active && !tick) ? tickCnt_q + 16'd1 : 16'd0;
        qtr_d      = qtr_q;
        bitCnt_d   = bitCnt_q;
        byteCnt_d  = byteCnt_q;
        waitCnt_d  = waitCnt_q;
        regIdx_d   = regIdx_q;
        subAddr_d  = subAddr_q;
        data_d     = data_q;
        doneFlag_d = doneFlag_q;
        sioc       = 1'b1;
        siod_out   = 1'b1;
        siod_oe    = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    regIdx_d   = 5'd0;
                    doneFlag_d = 1'b0;
                end
            end
            LOAD: begin
                subAddr_d = romSub;
                data_d    = romData;
                qtr_d     = 3'd0;
                state_d   = START;
            end
            START: begin
                siod_out = 1'b0;
                if (tick) begin
                    state_d   = BYTE;
                    qtr_d     = 3'd0;
                    bitCnt_d  = 4'd0;
                    byteCnt_d = 2'd0;
                end
            end
            BYTE: begin
                sioc = (qtr_q == 3'd1) || (qtr_q == 3'd2);
                if (bitCnt_q == 4'd8) begin
                    siod_oe = 1'b0;
                end else begin
                    siod_out = curByte[~bitCnt_q[2:0]];
                end
                if (tick) begin
                    if (qtr_q == 3'd3) begin
                        qtr_d = 3'd0;
                        if (bitCnt_q == 4'd8) begin
                            bitCnt_d = 4'd0;
                            if (byteCnt_q == 2'd2) begin
                                byteCnt_d = 2'd0;
                                state_d   = STOP;
                            end else begin
                                byteCnt_d = byteCnt_q + 2'd1;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            STOP: begin
                sioc     = (qtr_q != 3'd0);
                siod_out = 1'b0;
                if (tick) begin
                    if (qtr_q == 3'd1) begin
                        qtr_d   = 3'd0;
                        state_d = GAP;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (qtr_q == 3'd7) begin
                        qtr_d = 3'd0;
                        // The soft reset needs the camera to settle before anything else is written.
                        if ({subAddr_q, data_q} == 16'h1280) begin
                            state_d = RST_WAIT;
                        end else if (regIdx_q == 5'(N_REGS - 1)) begin
                            state_d = DONE;
                        end else begin
                            regIdx_d = regIdx_q + 5'd1;
                            state_d  = LOAD;
                        end
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
            end
            RST_WAIT: begin
                if (waitCnt_q == 32'(RST_CYC - 1)) begin
                    waitCnt_d = 32'd0;
                    regIdx_d  = regIdx_q + 5'd1;
                    state_d   = LOAD;
                end else begin
                    waitCnt_d = waitCnt_q + 32'd1;
                end
            end
            DONE: begin
                doneFlag_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = doneFlag_q || (state_q == DONE);
    assign reg_idx = regIdx_q;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Self-checking bench for cam_sccb_config: decodes the SCCB bus and compares writes against a table.
// Runs with a fast clock setting (quarter = 2 clk, settle = 800 clk) to keep full-table runs short.
module tb_cam_sccb_config;

    localparam int CLK_FREQ  = 800_000;
    localparam int SCCB_FREQ = 100_000;
    localparam int QEXP      = 2;
    localparam int RST_EXP   = 800;
`ifdef CAM_SCCB_TEST_PATTERN_EN
    localparam int NEXP = 11;
`else
    localparam int NEXP = 9;
`endif

    typedef struct {
        logic [4:0] idx;
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] dat;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sioc, siod_out, siod_oe, busy, done;
    logic [4:0] reg_idx;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    wr_t         expTab[NEXP];
    logic [23:0] frames[$];
    int          riseTimes[$];
    int          startIdle[$];
    int          oeErr = 0;
    logic        fallDoneOk = 1'b0;

    cam_sccb_config #(
        .CLK_FREQ(CLK_FREQ),
        .SCCB_FREQ(SCCB_FREQ),
        .CAM_ID(8'h42),
        .RST_WAIT_MS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sioc(sioc),
        .siod_out(siod_out),
        .siod_oe(siod_oe),
        .busy(busy),
        .done(done),
        .reg_idx(reg_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus decoder: SIOD reads as the pulled-up line when the master releases it.
    logic       prevSioc = 1'b1, prevSiod = 1'b1, inFrame = 1'b0, line;
    int         bitPos = 0, byteNum = 0, idleRun = 0;
    logic [7:0] shReg = '0;
    logic [23:0] frameReg = '0;
    always @(negedge clk) begin
        line = siod_oe ? siod_out : 1'b1;
        if (rst) begin
            inFrame  = 1'b0;
            prevSioc = 1'b1;
            prevSiod = 1'b1;
            idleRun  = 0;
        end else begin
            if (prevSioc && sioc && prevSiod && !line) begin
                inFrame = 1'b1; bitPos = 0; byteNum = 0; frameReg = '0;
                startIdle.push_back(idleRun);
            end else if (prevSioc && sioc && !prevSiod && line && inFrame) begin
                if (byteNum == 3) frames.push_back(frameReg);
                inFrame = 1'b0;
            end else if (!prevSioc && sioc && inFrame && byteNum < 3) begin
                riseTimes.push_back(cyc);
                if (bitPos == 8) begin
                    if (siod_oe) oeErr++;
                    frameReg = {frameReg[15:0], shReg};
                    byteNum++;
                    bitPos = 0;
                end else begin
                    if (!siod_oe) oeErr++;
                    shReg = {shReg[6:0], line};
                    bitPos++;
                end
            end
            idleRun  = (sioc && line) ? idleRun + 1 : 0;
            prevSioc = sioc;
            prevSiod = line;
        end
    end

    logic prevBusy = 1'b0, prevDone = 1'b0;
    always @(negedge clk) begin
        if (prevBusy && !busy) fallDoneOk = done && !prevDone;
        prevBusy = busy;
        prevDone = done;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input int n);
        rst   = r;
        start = s;
        repeat (n) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_sioc"}, 32'(sioc), 32'd1);
        checkOutput({tag, "_siod_out"}, 32'(siod_out), 32'd1);
        checkOutput({tag, "_siod_oe"}, 32'(siod_oe), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_reg_idx"}, 32'(reg_idx), 32'd0);
    endtask

    task automatic clearLog();
        frames.delete();
        riseTimes.delete();
        startIdle.delete();
        oeErr      = 0;
        fallDoneOk = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit ok = 0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(negedge clk);
            if (done && !busy) ok = 1;
        end
        if (!ok) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic waitIdx(input logic [4:0] k, input string tag);
        bit ok = 0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(negedge clk);
            if (busy && reg_idx == k) ok = 1;
        end
        if (!ok) checkOutput({tag, "_idx_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compareFrames(input string tag);
        checkOutput({tag, "_frame_count"}, 32'(frames.size()), 32'(NEXP));
        for (int i = 0; i < NEXP; i++) begin
            logic [23:0] act;
            act = (i < frames.size()) ? frames[i] : 24'h0;
            checkOutput($sformatf("%s_frame%0d", tag, expTab[i].idx), 32'(act),
                        32'({expTab[i].id, expTab[i].sub, expTab[i].dat}));
        end
    endtask

    initial begin
        expTab[0] = '{5'd0, 8'h42, 8'h12, 8'h80};
        expTab[1] = '{5'd1, 8'h42, 8'h12, 8'h04};
        expTab[2] = '{5'd2, 8'h42, 8'h8C, 8'h02};
        expTab[3] = '{5'd3, 8'h42, 8'h40, 8'hD0};
        expTab[4] = '{5'd4, 8'h42, 8'h11, 8'h01};
        expTab[5] = '{5'd5, 8'h42, 8'h0C, 8'h04};
        expTab[6] = '{5'd6, 8'h42, 8'h3E, 8'h1A};
        expTab[7] = '{5'd7, 8'h42, 8'h72, 8'h22};
        expTab[8] = '{5'd8, 8'h42, 8'h73, 8'hF2};
`ifdef CAM_SCCB_TEST_PATTERN_EN
        expTab[9]  = '{5'd9,  8'h42, 8'h70, 8'hBA};
        expTab[10] = '{5'd10, 8'h42, 8'h71, 8'hB5};
`endif
        rst   = 1'b1;
        start = 1'b0;

        $display("[TB] reset for 3 cycles");
        applyStimulus(1'b1, 1'b0, 3);
        @(negedge clk);
        checkIdleBus("reset");

        $display("[TB] full configuration run");
        clearLog();
        applyStimulus(1'b0, 1'b1, 1);
        @(negedge clk);
        checkOutput("run1_busy_after_start", 32'(busy), 32'd1);
        waitDone("run1");
        compareFrames("run1");
        checkOutput("run1_oe_ninth_bit", 32'(oeErr), 32'd0);
        checkOutput("run1_done_busy_same_edge", 32'(fallDoneOk), 32'd1);
        checkOutput("run1_sioc_period", riseTimes.size() > 1 ? 32'(riseTimes[1] - riseTimes[0]) : 32'd0,
                    32'(4 * QEXP));
        checkOutput("run1_sioc_period_byte_edge", riseTimes.size() > 9 ? 32'(riseTimes[9] - riseTimes[8]) : 32'd0,
                    32'(4 * QEXP));
        checkOutput("run1_settle_idle", startIdle.size() > 1 ? 32'(startIdle[1] >= RST_EXP) : 32'd0, 32'd1);
        checkOutput("run1_final_idx", 32'(reg_idx), 32'(NEXP - 1));
        repeat (5) @(negedge clk);
        checkOutput("run1_done_held", 32'(done), 32'd1);
        checkOutput("run1_idx_held", 32'(reg_idx), 32'(NEXP - 1));

        $display("[TB] second start during entry 4");
        clearLog();
        applyStimulus(1'b0, 1'b1, 1);
        @(negedge clk);
        checkOutput("run2_done_cleared", 32'(done), 32'd0);
        checkOutput("run2_idx_restart", 32'(reg_idx), 32'd0);
        waitIdx(5'd4, "run2");
        applyStimulus(1'b0, 1'b1, 1);
        @(negedge clk);
        checkOutput("run2_idx_unchanged", 32'(reg_idx), 32'd4);
        checkOutput("run2_still_busy", 32'(busy), 32'd1);
        waitDone("run2");
        compareFrames("run2");

        $display("[TB] reset during entry 3");
        clearLog();
        applyStimulus(1'b0, 1'b1, 1);
        waitIdx(5'd3, "run3");
        repeat (20) @(negedge clk);
        checkOutput("run3_busy_before_abort", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1);
        @(negedge clk);
        checkIdleBus("abort");
        checkOutput("abort_frames_before", 32'(frames.size()), 32'd3);
        clearLog();
        applyStimulus(1'b0, 1'b1, 1);
        begin
            bit got = 0;
            for (int n = 0; n < 5000 && !got; n++) begin
                @(negedge clk);
                if (frames.size() > 0) got = 1;
            end
            if (!got) checkOutput("restart_frame_timeout", 32'd0, 32'd1);
        end
        checkOutput("restart_first_frame", frames.size() > 0 ? 32'(frames[0]) : 32'd0, 32'h421280);

        $display("[TB] start coincident with reset");
        applyStimulus(1'b1, 1'b1, 1);
        repeat (3) @(negedge clk);
        checkOutput("rst_start_busy", 32'(busy), 32'd0);
        checkOutput("rst_start_idx", 32'(reg_idx), 32'd0);
        checkOutput("rst_start_sioc", 32'(sioc), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
